// File: rtl/sys_arr_grid.sv
// Weight-stationary ROWS x COLS systolic MAC array with weight-load sequencer,
// input skew, output deskew and valid/ready input handshake. COLS must be >= 2.
// Define SYS_ARR_SAT_EN to saturate every PE accumulation instead of wrapping.
module sys_arr_grid #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 8,
  parameter int SUM_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wload_start,
  input  logic [COLS*DATA_W-1:0] win,
  output logic                   wload_done,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ROWS*DATA_W-1:0] datain,
  output logic                   out_valid,
  output logic [COLS*SUM_W-1:0]  maccout,
  output logic                   busy
);
  localparam int LAT = ROWS + COLS - 1;
  localparam int CW  = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [0:0] {IDLE = 1'b0, WLOAD = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [LAT-1:0]           tok_q, tok_d;
  logic                     out_valid_q, out_valid_d;
  logic [COLS*SUM_W-1:0]    mac_q, mac_d;
  logic signed [DATA_W-1:0] w_q  [ROWS][COLS];
  logic signed [DATA_W-1:0] w_d  [ROWS][COLS];
  logic signed [DATA_W-1:0] ad_q [ROWS][COLS-1];
  logic signed [DATA_W-1:0] ad_d [ROWS][COLS-1];
  logic signed [SUM_W-1:0]  s_q  [ROWS][COLS];
  logic signed [SUM_W-1:0]  s_d  [ROWS][COLS];
  logic signed [DATA_W-1:0] pa   [ROWS][COLS];
  logic signed [DATA_W-1:0] a_in [ROWS];
  logic signed [SUM_W-1:0]  bot  [COLS];
  logic                     xfer;

  function automatic logic signed [SUM_W-1:0] pe_mac(
    input logic signed [SUM_W-1:0]  s,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] w
  );
    logic signed [2*DATA_W-1:0] p;
`ifdef SYS_ARR_SAT_EN
    logic signed [SUM_W:0] t;
    p = a * w;
    t = (SUM_W+1)'(s) + (SUM_W+1)'(p);
    if (t[SUM_W] != t[SUM_W-1]) begin
      pe_mac = t[SUM_W] ? {1'b1, {(SUM_W-1){1'b0}}} : {1'b0, {(SUM_W-1){1'b1}}};
    end else begin
      pe_mac = t[SUM_W-1:0];
    end
`else
    p = a * w;
    pe_mac = s + SUM_W'(p);
`endif
  endfunction

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state: a load request is only honoured while nothing is in flight
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = {CW{1'b0}};
        if (wload_start && !busy) state_d = WLOAD;
        else                      state_d = IDLE;
      end
      WLOAD: begin
        if (cnt_q == CW'(ROWS-1)) begin
          state_d = IDLE;
          cnt_d   = {CW{1'b0}};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready   = (state_q == IDLE) && !wload_start;
    wload_done = (state_q == WLOAD) && (cnt_q == CW'(ROWS-1));
    busy       = (state_q == WLOAD) || (|tok_q);
  end

  assign xfer      = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign maccout   = mac_q;

  // Weight shift during load, PE grid update, token pipe and output capture
  always_comb begin
    if (state_q == WLOAD) begin
      for (int c = 0; c < COLS; c++) w_d[0][c] = win[c*DATA_W +: DATA_W];
      for (int r = 1; r < ROWS; r++) w_d[r] = w_q[r-1];
    end else begin
      w_d = w_q;
    end
    for (int r = 0; r < ROWS; r++) begin
      pa[r][0] = a_in[r];
      for (int c = 1; c < COLS; c++) pa[r][c] = ad_q[r][c-1];
      for (int c = 0; c < COLS-1; c++) ad_d[r][c] = pa[r][c];
    end
    for (int c = 0; c < COLS; c++) begin
      s_d[0][c] = pe_mac({SUM_W{1'b0}}, pa[0][c], w_q[0][c]);
      for (int r = 1; r < ROWS; r++) s_d[r][c] = pe_mac(s_q[r-1][c], pa[r][c], w_q[r][c]);
    end
    tok_d       = {tok_q[LAT-2:0], xfer};
    out_valid_d = tok_q[LAT-1];
    mac_d       = mac_q;
    if (tok_q[LAT-1]) begin
      for (int c = 0; c < COLS; c++) mac_d[c*SUM_W +: SUM_W] = bot[c];
    end else begin
      mac_d = mac_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          w_q[r][c] <= {DATA_W{1'b0}};
          s_q[r][c] <= {SUM_W{1'b0}};
        end
        for (int c = 0; c < COLS-1; c++) ad_q[r][c] <= {DATA_W{1'b0}};
      end
      tok_q       <= {LAT{1'b0}};
      out_valid_q <= 1'b0;
      mac_q       <= {(COLS*SUM_W){1'b0}};
    end else begin
      w_q         <= w_d;
      s_q         <= s_d;
      ad_q        <= ad_d;
      tok_q       <= tok_d;
      out_valid_q <= out_valid_d;
      mac_q       <= mac_d;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    logic signed [DATA_W-1:0] row_in;
    assign row_in = xfer ? datain[r*DATA_W +: DATA_W] : {DATA_W{1'b0}};
    if (r == 0) begin : g_direct
      assign a_in[r] = row_in;
    end else begin : g_dly
      logic signed [DATA_W-1:0] sk_q [r];
      logic signed [DATA_W-1:0] sk_d [r];
      // Row r enters the grid r cycles late
      always_comb begin
        sk_d[0] = row_in;
        for (int i = 1; i < r; i++) sk_d[i] = sk_q[i-1];
      end
      // Skew line registers
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < r; i++) sk_q[i] <= {DATA_W{1'b0}};
        end else begin
          sk_q <= sk_d;
        end
      end
      assign a_in[r] = sk_q[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_deskew
    localparam int D = COLS - 1 - c;
    if (D == 0) begin : g_direct
      assign bot[c] = s_q[ROWS-1][c];
    end else begin : g_dly
      logic signed [SUM_W-1:0] dk_q [D];
      logic signed [SUM_W-1:0] dk_d [D];
      // Earlier columns wait for the last column to finish
      always_comb begin
        dk_d[0] = s_q[ROWS-1][c];
        for (int i = 1; i < D; i++) dk_d[i] = dk_q[i-1];
      end
      // Deskew line registers
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < D; i++) dk_q[i] <= {SUM_W{1'b0}};
        end else begin
          dk_q <= dk_d;
        end
      end
      assign bot[c] = dk_q[D-1];
    end
  end
endmodule

// File: doc/sys_arr_grid.md
Name: sys_arr_grid

Overview:
- Parametrised weight-stationary systolic array of ROWS x COLS multiply-accumulate PEs, with independent row and column counts and configurable data/sum widths.
- Built-in weight-load sequencer, input skew registers, output deskew registers and valid/ready handshake on input.
- Callers present one aligned data vector per cycle and receive one aligned result vector per cycle.
- Sits between the unified input buffer and the accumulator bank in the MMU, replacing the hand-wired square array.

Parameters:
- ROWS, 4, PE rows; one data lane per row.
- COLS, 4, PE columns; one weight lane and one sum lane per column.
- DATA_W, 8, signed data and weight width.
- SUM_W, 16, signed partial-sum width; must be at least 2*DATA_W.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- wload_start  in  1  request a weight load; sampled only when busy=0.
- win  in  COLS*DATA_W  one weight row per cycle during WLOAD; column 0 in the LSBs.
- wload_done  out  1  one-cycle pulse when the final weight row is latched.
- in_valid  in  1  datain is valid.
- in_ready  out  1  array accepts datain this cycle.
- datain  in  ROWS*DATA_W  data vector; row 0 in the LSBs.
- out_valid  out  1  maccout is valid.
- maccout  out  COLS*SUM_W  aligned column sums; column 0 in the LSBs.
- busy  out  1  WLOAD active or any valid token in flight.

Behaviour:
- Reset values: all weights, skew, PE and deskew registers = 0; state = IDLE; in_ready = 1 once reset is released; wload_done, out_valid, busy = 0; maccout = 0.
- FSM has two states, IDLE and WLOAD.
- IDLE -> WLOAD when wload_start=1 and busy=0. A wload_start while busy=1 is ignored (not queued).
- In WLOAD, a counter runs 0..ROWS-1. Each cycle, win is latched into row 0 and every row's weights shift down one row.
  - The first word presented therefore ends in row ROWS-1 and the last word in row 0.
  - wload_done pulses on the cycle the counter reaches ROWS-1; next state is IDLE.
  - Load takes exactly ROWS cycles.
- in_ready = (state==IDLE) and not wload_start. When both are asserted in IDLE with busy=0, the weight load wins.
- Transfer occurs when in_valid=1 and in_ready=1.
  - On no transfer, a bubble enters: data = 0, token = 0.
  - Loaded weights are held unchanged during compute.
- Skew: row r's data is delayed r cycles.
- PE(r,c), registered each cycle:
  - sum_out = sum_in + data*weight, signed.
  - Row 0's sum_in = 0.
  - Data passes right one PE per cycle.
- Deskew: column c's bottom sum is delayed COLS-1-c cycles.
- Latency L = ROWS+COLS-1 cycles. A vector accepted at edge k has out_valid=1 and maccout[c] = sum over r of datain[r]*W[r][c] during the cycle after edge k+L.
- Throughput is one vector per cycle; streaming is fully pipelined with no gaps.
- There is no output backpressure; the consumer must accept every out_valid cycle.
- maccout holds its last value when out_valid=0.
- A valid-token shift register of length L drives out_valid and busy.
- Arithmetic is two's complement; overflow wraps modulo 2^SUM_W.
- Reset mid-operation clears weights, in-flight tokens and the FSM immediately. No out_valid is produced for vectors accepted before reset.

Optional Feature:
- SYS_ARR_SAT_EN defined: every PE accumulation saturates to [-2^(SUM_W-1), 2^(SUM_W-1)-1] instead of wrapping. Latency is unchanged.
- SYS_ARR_SAT_EN undefined: wrap-around arithmetic as above.

Test Plan:
- Reset then a single vector (ROWS=COLS=4, no load, all datain=5) -> weights are 0, so maccout=0 with out_valid high exactly 7 cycles after acceptance; in_ready=1 throughout.
- ROWS=COLS=2: load win = {4,3} then {2,1} (row 1 first) -> wload_done on the 2nd load cycle. Then datain=(2,3) -> maccout col0=11, col1=16, out_valid 3 cycles after acceptance.
- 2x2, all weights = -128, datain=(-128,-128) -> col sums 0x8000 (wrap). With SYS_ARR_SAT_EN -> 0x7FFF.
- Stream 4 vectors back-to-back, one bubble, then 2 more -> out_valid pattern 1111011 beginning L cycles after the first, each maccout matching the golden model.
- wload_start while tokens are in flight -> ignored and weights unchanged. wload_start with in_valid in idle -> in_ready=0 and WLOAD entered.
- Reset asserted mid-stream with 3 tokens in flight -> out_valid stays 0, maccout=0, busy=0; a subsequent load and vector complete correctly.
